// File: rtl/sm_run_ctrl_pkg.sv
// Shared definitions for the schoolRISCV run-control sequencer:
// command op codes, state encodings and field widths.
package sm_run_ctrl_pkg;

    localparam int RC_OP_W    = 2;
    localparam int RC_ST_W    = 2;
    localparam int RC_CNT_W   = 32;

    typedef enum logic [RC_OP_W-1:0] {
        RC_OP_HALT    = 2'b00,
        RC_OP_RUN     = 2'b01,
        RC_OP_STEP    = 2'b10,
        RC_OP_CLR_CNT = 2'b11
    } rc_op_e;

    typedef enum logic [RC_ST_W-1:0] {
        RC_ST_HALT = 2'b00,
        RC_ST_RUN  = 2'b01,
        RC_ST_STEP = 2'b10
    } rc_state_e;

    // True in the states where the CPU is allowed to advance.
    function automatic logic rc_is_active(input rc_state_e st);
        return (st == RC_ST_RUN) || (st == RC_ST_STEP);
    endfunction

endpackage

// File: rtl/sm_run_ctrl_bp.sv
// PC breakpoint comparator with a one-shot skip flag, so that resuming
// from a breakpoint executes the instruction at the breakpoint once.
module sm_run_ctrl_bp #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                bp_en,
    input  logic [PC_WIDTH-1:0] bp_addr,
    input  logic                arm,     // resume from HALT: ignore the current match once
    input  logic                cpu_en,  // first enabled cycle consumes the skip
    output logic                bp_hit
);

    logic bp_skip_q;
    logic bp_skip_d;

    // Skip flag: set on resume, cleared by the first executed instruction.
    always_comb begin
        bp_skip_d = bp_skip_q;
        if (arm) begin
            bp_skip_d = 1'b1;
        end else if (cpu_en) begin
            bp_skip_d = 1'b0;
        end
    end

    // Skip flag register; clear at reset so a breakpoint on the reset vector is honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_skip_q <= 1'b0;
        end else begin
            bp_skip_q <= bp_skip_d;
        end
    end

    assign bp_hit = bp_en && (pc == bp_addr) && !bp_skip_q;

endmodule

// File: rtl/sm_run_ctrl.sv
// Run-control sequencer for the schoolRISCV core: gates the CPU clock enable
// for halt / run / N-step operation and counts enabled CPU cycles.
// Optional breakpoint support is built when SM_RUN_CTRL_BREAKPOINT_EN is defined;
// otherwise bp_en/bp_addr are accepted but ignored.
module sm_run_ctrl
    import sm_run_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int STEP_WIDTH = 16,
    parameter bit RESET_RUN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [RC_OP_W-1:0]    cmd_op,
    input  logic [STEP_WIDTH-1:0] cmd_arg,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  bp_en,
    input  logic [PC_WIDTH-1:0]   bp_addr,
    output logic                  cpu_en,
    output logic [RC_ST_W-1:0]    state,
    output logic                  halt_evt,
    output logic [RC_CNT_W-1:0]   cycle_cnt
);

    localparam rc_state_e RST_STATE = rc_state_e'(RESET_RUN ? RC_ST_RUN : RC_ST_HALT);

    rc_state_e             state_q, state_d;
    logic [STEP_WIDTH-1:0] remaining_q, remaining_d;
    logic [RC_CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic                  halt_evt_q, halt_evt_d;
    logic                  cmd_fire;
    logic                  skip_arm;
    logic                  bp_hit;

    assign cmd_fire = cmd_valid && cmd_ready;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
    sm_run_ctrl_bp #(
        .PC_WIDTH (PC_WIDTH)
    ) u_bp (
        .clk     (clk),
        .rst     (rst),
        .pc      (pc),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .arm     (skip_arm),
        .cpu_en  (cpu_en),
        .bp_hit  (bp_hit)
    );
`else
    // Breakpoints compiled out: the inputs are intentionally left without effect.
    logic unused_bp_inputs;
    assign unused_bp_inputs = ^{bp_en, bp_addr, pc, skip_arm};
    assign bp_hit           = 1'b0;
`endif

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            remaining_q <= '0;
            cycle_cnt_q <= '0;
            halt_evt_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cycle_cnt_q <= cycle_cnt_d;
            halt_evt_q  <= halt_evt_d;
        end
    end

    // Next-state logic: command decode, step counting and breakpoint exit.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        skip_arm    = 1'b0;
        case (state_q)
            RC_ST_HALT: begin
                if (cmd_fire && (cmd_op == RC_OP_RUN)) begin
                    state_d  = RC_ST_RUN;
                    skip_arm = 1'b1;
                end else if (cmd_fire && (cmd_op == RC_OP_STEP) && (cmd_arg != '0)) begin
                    state_d     = RC_ST_STEP;
                    remaining_d = cmd_arg;
                    skip_arm    = 1'b1;
                end
            end
            RC_ST_RUN: begin
                // A breakpoint and a HALT command together still mean one HALT entry.
                if (bp_hit || (cmd_fire && (cmd_op == RC_OP_HALT))) begin
                    state_d = RC_ST_HALT;
                end
            end
            RC_ST_STEP: begin
                if (bp_hit) begin
                    state_d     = RC_ST_HALT;
                    remaining_d = '0;
                end else if (cpu_en) begin
                    if (remaining_q == STEP_WIDTH'(1)) begin
                        state_d     = RC_ST_HALT;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - STEP_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d     = RC_ST_HALT;
                remaining_d = '0;
            end
        endcase
    end

    // Output logic: CPU enable and command handshake derived from registered state.
    always_comb begin
        cpu_en    = rc_is_active(state_q) && !bp_hit;
        cmd_ready = (state_q != RC_ST_STEP);
    end

    // Cycle counter and HALT-entry pulse; a clear request beats a concurrent increment.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cmd_fire && (cmd_op == RC_OP_CLR_CNT)) begin
            cycle_cnt_d = '0;
        end else if (cpu_en) begin
            cycle_cnt_d = cycle_cnt_q + RC_CNT_W'(1);
        end
        halt_evt_d = (state_d == RC_ST_HALT) && (state_q != RC_ST_HALT);
    end

    assign state     = state_q;
    assign halt_evt  = halt_evt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl. dut0 resets to HALT, dut1 resets to RUN.
// Breakpoint expectations follow SM_RUN_CTRL_BREAKPOINT_EN.
module tb_sm_run_ctrl;

    localparam int W = 10;   // observation window per table vector

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid0 = 1'b0;
    logic        cmd_valid1 = 1'b0;
    logic [1:0]  cmd_op  = 2'b00;
    logic [15:0] cmd_arg = '0;
    logic        bp_en   = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] pc0, pc1;
    logic        cmd_ready0, cmd_ready1, cpu_en0, cpu_en1, halt_evt0, halt_evt1;
    logic [1:0]  state0, state1;
    logic [31:0] cycle_cnt0, cycle_cnt1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sm_run_ctrl #(.PC_WIDTH(32), .STEP_WIDTH(16), .RESET_RUN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc0), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en0), .state(state0), .halt_evt(halt_evt0), .cycle_cnt(cycle_cnt0)
    );

    sm_run_ctrl #(.PC_WIDTH(32), .STEP_WIDTH(16), .RESET_RUN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .pc(pc1), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en1), .state(state1), .halt_evt(halt_evt1), .cycle_cnt(cycle_cnt1)
    );

    // Minimal CPU models: pc advances by 4 on every enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc0 <= '0;
        else if (cpu_en0) pc0 <= pc0 + 32'd4;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc1 <= '0;
        else if (cpu_en1) pc1 <= pc1 + 32'd4;
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] arg;
        logic [1:0]  exp_state;
        int          exp_en;
        int          exp_evt;
        int          exp_nrdy;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) at negedges until pc1 reaches target.
    task automatic wait_pc1(input logic [31:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (pc1 == target) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Issues one command to dut0 and observes W cycles; expected record goes through the scoreboard.
    task automatic run_vec(input int idx, input vec_t v);
        int en, ev, nr;
        vec_t e;
        cmd_op     = v.op;
        cmd_arg    = v.arg;
        cmd_valid0 = 1'b1;
        sb.push_back(v);
        en = 0; ev = 0; nr = 0;
        for (int i = 0; i <= W; i++) begin
            en += int'(cpu_en0);
            ev += int'(halt_evt0);
            nr += int'(!cmd_ready0);
            @(posedge clk);
            @(negedge clk);
            cmd_valid0 = 1'b0;
        end
        e = sb.pop_front();
        $display("vec %0d op=%0d arg=%0d state=%0d en=%0d evt=%0d nrdy=%0d cnt=%0d",
                 idx, e.op, e.arg, state0, en, ev, nr, cycle_cnt0);
        chk("vec_state", 32'(state0), 32'(e.exp_state));
        chk("vec_en_cycles", 32'(en), 32'(e.exp_en));
        chk("vec_halt_evt", 32'(ev), 32'(e.exp_evt));
        chk("vec_not_ready", 32'(nr), 32'(e.exp_nrdy));
        chk("vec_cycle_cnt", cycle_cnt0, e.exp_cnt);
    endtask

    initial begin
        bit ok;
        int ev;

        //            op     arg  state  en  evt nrdy cnt
        vecs[0] = '{2'b10, 16'd3, 2'b00,  3, 1,  3,  32'd3};
        vecs[1] = '{2'b10, 16'd0, 2'b00,  0, 0,  0,  32'd3};
        vecs[2] = '{2'b00, 16'd0, 2'b00,  0, 0,  0,  32'd3};
        vecs[3] = '{2'b10, 16'd1, 2'b00,  1, 1,  1,  32'd4};
        vecs[4] = '{2'b11, 16'd0, 2'b00,  0, 0,  0,  32'd0};
        vecs[5] = '{2'b10, 16'd6, 2'b00,  6, 1,  6,  32'd6};
        vecs[6] = '{2'b01, 16'd0, 2'b01, 10, 0,  0,  32'd16};
        vecs[7] = '{2'b10, 16'd4, 2'b01, 11, 0,  0,  32'd27};
        vecs[8] = '{2'b11, 16'd0, 2'b01, 11, 0,  0,  32'd10};
        vecs[9] = '{2'b00, 16'd0, 2'b00,  1, 1,  0,  32'd11};

        // Reset state, checked while rst is held.
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        #12;
        chk("rst_state0", 32'(state0), 32'd0);
        chk("rst_state1", 32'(state1), 32'd1);
        chk("rst_cnt0", cycle_cnt0, 32'd0);
        chk("rst_evt0", 32'(halt_evt0), 32'd0);
        chk("rst_cpu_en0", 32'(cpu_en0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Breakpoint at 0x10 on the free-running dut1, then resume past it.
        wait_pc1(32'h10, ok);
        chk("bp_reach_pc10", 32'(ok), 32'd1);
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        chk("bp_cpu_en_low", 32'(cpu_en1), 32'd0);
        @(negedge clk);
        chk("bp_state_halt", 32'(state1), 32'd0);
        chk("bp_halt_evt", 32'(halt_evt1), 32'd1);
        chk("bp_cycle_cnt", cycle_cnt1, 32'd4);
        @(negedge clk);
        chk("bp_evt_one_cycle", 32'(halt_evt1), 32'd0);
        chk("bp_pc_held", pc1, 32'h10);
        cmd_op     = 2'b01;
        cmd_valid1 = 1'b1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        chk("bp_resume_state", 32'(state1), 32'd1);
        chk("bp_resume_en", 32'(cpu_en1), 32'd1);
        @(negedge clk);
        chk("bp_resume_pc", pc1, 32'h14);
        chk("bp_no_rebreak", 32'(cpu_en1), 32'd1);
`else
        chk("bp_ignored_en", 32'(cpu_en1), 32'd1);
        @(negedge clk);
        chk("bp_ignored_pc", pc1, 32'h14);
        chk("bp_ignored_state", 32'(state1), 32'd1);
`endif

        // Table of single-command transactions on dut0.
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Breakpoint on the reset vector.
        bp_addr = 32'h0;
        pulse_reset();
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        chk("rv_cpu_en", 32'(cpu_en1), 32'd0);
        @(negedge clk);
        chk("rv_state", 32'(state1), 32'd0);
        chk("rv_cnt", cycle_cnt1, 32'd0);
`else
        chk("rv_cpu_en", 32'(cpu_en1), 32'd1);
        @(negedge clk);
        chk("rv_state", 32'(state1), 32'd1);
        chk("rv_cnt", cycle_cnt1, 32'd1);
`endif

        // HALT command in the same cycle as a breakpoint match.
        bp_addr = 32'h20;
        pulse_reset();
        wait_pc1(32'h20, ok);
        chk("hb_reach_pc20", 32'(ok), 32'd1);
        cmd_op     = 2'b00;
        cmd_valid1 = 1'b1;
        ev = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid1 = 1'b0;
            ev += int'(halt_evt1);
        end
        chk("hb_single_evt", 32'(ev), 32'd1);
        chk("hb_state", 32'(state1), 32'd0);
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
        chk("hb_cnt", cycle_cnt1, 32'd8);
`else
        chk("hb_cnt", cycle_cnt1, 32'd9);
`endif

        // Counter wrap from a preloaded all-ones value.
        bp_en = 1'b0;
        @(negedge clk);
        force dut0.cycle_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut0.cycle_cnt_q;
        chk("wrap_preload", cycle_cnt0, 32'hFFFF_FFFF);
        cmd_op     = 2'b10;
        cmd_arg    = 16'd2;
        cmd_valid0 = 1'b1;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        chk("wrap_before", cycle_cnt0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("wrap_zero", cycle_cnt0, 32'd0);
        @(negedge clk);
        chk("wrap_one", cycle_cnt0, 32'd1);
        chk("wrap_state", 32'(state0), 32'd0);

        // Asynchronous reset in the middle of a long step sequence.
        cmd_op     = 2'b10;
        cmd_arg    = 16'd100;
        cmd_valid0 = 1'b1;
        @(negedge clk);
        cmd_valid0 = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        chk("ms_in_step", 32'(state0), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("ms_state", 32'(state0), 32'd0);
        chk("ms_cpu_en", 32'(cpu_en0), 32'd0);
        chk("ms_cnt", cycle_cnt0, 32'd0);
        chk("ms_evt", 32'(halt_evt0), 32'd0);
        chk("ms_remaining", 32'(dut0.remaining_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ev = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ev += int'(halt_evt0);
        end
        chk("ms_no_evt", 32'(ev), 32'd0);
        chk("ms_state_after", 32'(state0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
